// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// plus an auto-serialise engine that loads a word and shifts it out over WIDTH cycles.
module universal_shift_reg #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_lsb,
    output logic             serial_out_msb,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_shr;
    logic [WIDTH-1:0]   w_shl;
    logic               w_last;

    assign w_shr  = {serial_in_left, r_data[WIDTH-1:1]};
    assign w_shl  = {r_data[WIDTH-2:0], serial_in_right};
    // Counter holds WIDTH-1 on the edge that performs the final shift.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_data  <= RESET_VALUE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_data  <= parallel_in;
                        r_dir   <= dir;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        case (mode)
                            2'b00: r_data <= r_data;
                            2'b01: r_data <= w_shr;
                            2'b10: r_data <= w_shl;
                            2'b11: r_data <= parallel_in;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    r_data <= r_dir ? w_shl : w_shr;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign parallel_out   = r_data;
    assign serial_out_lsb = r_data[0];
    assign serial_out_msb = r_data[WIDTH-1];
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=4 and WIDTH=8 instances).
module tb_universal_shift_reg;

    logic       clk;
    logic       reset;

    logic [1:0] mode4;
    logic [3:0] pin4;
    logic       sil4, sir4, start4, dir4;
    logic [3:0] pout4;
    logic       slsb4, smsb4, busy4, done4;

    logic [1:0] mode8;
    logic [7:0] pin8;
    logic       sil8, sir8, start8, dir8;
    logic [7:0] pout8;
    logic       slsb8, smsb8, busy8, done8;

    int n_checks;
    int n_errors;

    universal_shift_reg #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .mode(mode4), .parallel_in(pin4),
        .serial_in_left(sil4), .serial_in_right(sir4), .start(start4), .dir(dir4),
        .parallel_out(pout4), .serial_out_lsb(slsb4), .serial_out_msb(smsb4),
        .busy(busy4), .done(done4)
    );

    universal_shift_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .mode(mode8), .parallel_in(pin8),
        .serial_in_left(sil8), .serial_in_right(sir8), .start(start8), .dir(dir8),
        .parallel_out(pout8), .serial_out_lsb(slsb8), .serial_out_msb(smsb8),
        .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_bits;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        mode4 = 2'b00; pin4 = 4'h0; sil4 = 1'b0; sir4 = 1'b0; start4 = 1'b0; dir4 = 1'b0;
        mode8 = 2'b00; pin8 = 8'h0; sil8 = 1'b0; sir8 = 1'b0; start8 = 1'b0; dir8 = 1'b0;

        // 1: reset held for 5 clocks, then async reset between edges
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_pout4", 32'(pout4), 32'h0);
            check("rst_busy4", 32'(busy4), 32'h0);
            check("rst_done4", 32'(done4), 32'h0);
        end
        check("rst_pout8", 32'(pout8), 32'h0);
        check("rst_busy8", 32'(busy8), 32'h0);
        reset = 1'b1;
        mode4 = 2'b11; pin4 = 4'b1010;
        tick();
        check("load_1010", 32'(pout4), 32'hA);
        mode4 = 2'b00;
        #2 reset = 1'b0;
        #1;
        check("async_rst_pout4", 32'(pout4), 32'h0);
        tick();
        reset = 1'b1;

        // 2: parallel load then hold
        mode4 = 2'b11; pin4 = 4'b0010;
        tick();
        check("load_0010", 32'(pout4), 32'h2);
        mode4 = 2'b00; pin4 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_0010", 32'(pout4), 32'h2);
        end

        // 3: shift right fill 1, then shift left fill 0
        mode4 = 2'b11; pin4 = 4'b1001;
        tick();
        check("load_1001", 32'(pout4), 32'h9);
        mode4 = 2'b01; sil4 = 1'b1;
        tick();
        check("shr_1", 32'(pout4), 32'hC);
        tick();
        check("shr_2", 32'(pout4), 32'hE);
        check("smsb4", 32'(smsb4), 32'h1);
        mode4 = 2'b10; sir4 = 1'b0;
        tick();
        check("shl_1", 32'(pout4), 32'hC);
        tick();
        check("shl_2", 32'(pout4), 32'h8);
        check("slsb4", 32'(slsb4), 32'h0);
        mode4 = 2'b00;

        // 4: auto-serialise right, A5, with mid-transfer disturbance
        exp_bits = 8'b1010_0101;
        pin8 = 8'hA5; dir8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("a5_lsb", 32'(slsb8), 32'(exp_bits[i]));
            check("a5_busy", 32'(busy8), 32'h1);
            check("a5_done", 32'(done8), 32'h0);
            if (i == 3) begin
                mode8 = 2'b11; start8 = 1'b1; pin8 = 8'hFF; dir8 = 1'b1;
            end else begin
                mode8 = 2'b00; start8 = 1'b0; dir8 = 1'b0;
            end
            tick();
        end
        check("a5_end_busy", 32'(busy8), 32'h0);
        check("a5_end_done", 32'(done8), 32'h1);
        check("a5_end_pout", 32'(pout8), 32'h00);
        tick();
        check("a5_done_clr", 32'(done8), 32'h0);
        check("a5_idle_pout", 32'(pout8), 32'h00);

        // 5: auto-serialise left, 3C, then back-to-back FF
        exp_bits = 8'h3C;
        pin8 = 8'h3C; dir8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("3c_msb", 32'(smsb8), 32'(exp_bits[7-i]));
            check("3c_busy", 32'(busy8), 32'h1);
            tick();
        end
        check("3c_done", 32'(done8), 32'h1);
        check("3c_busy_lo", 32'(busy8), 32'h0);
        pin8 = 8'hFF; dir8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; pin8 = 8'h00;
        check("b2b_busy", 32'(busy8), 32'h1);
        check("b2b_done_clr", 32'(done8), 32'h0);
        check("b2b_pout", 32'(pout8), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            check("ff_msb", 32'(smsb8), 32'h1);
            tick();
        end
        check("ff_done", 32'(done8), 32'h1);
        check("ff_pout", 32'(pout8), 32'h00);
        tick();

        // 6: reset during the third shift cycle aborts without done
        pin8 = 8'hA5; dir8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 32'(busy8), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'h0);
        check("abort_pout", 32'(pout8), 32'h00);
        check("abort_done", 32'(done8), 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_done", 32'(done8), 32'h0);
        end
        exp_bits = 8'h3C;
        pin8 = 8'h3C; dir8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("post_lsb", 32'(slsb8), 32'(exp_bits[i]));
            check("post_busy", 32'(busy8), 32'h1);
            tick();
        end
        check("post_done", 32'(done8), 32'h1);
        tick();
        check("post_done_clr", 32'(done8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the team's fixed 4-bit parallel-in/parallel-out register.
- Four modes, selected per cycle:
  - hold
  - shift right with serial fill
  - shift left with serial fill
  - parallel load
- Adds an auto-serialise engine: one start pulse loads a word and shifts it out over WIDTH cycles, with busy/done status.
- Used as a generic staging register and as a parallel-to-serial front end for serial links.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- mode  input  2  manual operation, used only when idle: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- parallel_in  input  WIDTH  data for parallel load and for start.
- serial_in_left  input  1  bit entering the MSB on a right shift.
- serial_in_right  input  1  bit entering the LSB on a left shift.
- start  input  1  begin auto-serialise; sampled only when idle.
- dir  input  1  auto-serialise direction, sampled with start: 0 = right (LSB first), 1 = left (MSB first).
- parallel_out  output  WIDTH  register contents.
- serial_out_lsb  output  1  combinational, equals parallel_out[0].
- serial_out_msb  output  1  combinational, equals parallel_out[WIDTH-1].
- busy  output  1  high while auto-serialise is active.
- done  output  1  one-cycle pulse marking the end of auto-serialise.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - parallel_out=RESET_VALUE, busy=0, done=0.
  - FSM goes to IDLE, shift counter=0, latched direction=0.
  - Reset mid-operation aborts the transfer immediately; no done pulse is produced.
- FSM states: IDLE, SHIFT.
- IDLE with start=0, applied each rising edge:
  - 00: parallel_out unchanged.
  - 01: parallel_out <= {serial_in_left, parallel_out[WIDTH-1:1]}.
  - 10: parallel_out <= {parallel_out[WIDTH-2:0], serial_in_right}.
  - 11: parallel_out <= parallel_in.
- IDLE with start=1:
  - start takes priority over mode; mode is ignored that cycle.
  - Edge k: parallel_out<=parallel_in, latch dir, counter<=0, busy<=1, go to SHIFT.
- SHIFT:
  - Each edge shifts one position in the latched direction. Fill bit is serial_in_left for right, serial_in_right for left. Counter increments.
  - mode, start and dir are ignored.
  - The edge that performs the WIDTH-th shift (edge k+WIDTH) also returns to IDLE, sets busy<=0 and done<=1.
  - busy is therefore high for exactly WIDTH cycles.
- Serial data timing:
  - Bit i of the word (LSB-first for right, MSB-first for left) is on serial_out_lsb (right) or serial_out_msb (left) in the cycle after edge k+i, for i=0..WIDTH-1.
- done:
  - Registered; high for exactly the one cycle after edge k+WIDTH, cleared on the next edge.
  - A start in that cycle is accepted (back-to-back transfers). done still deasserts on schedule.
- Counter: width ceil(log2(WIDTH+1)); never exceeds WIDTH.
- No X propagation required beyond the inputs themselves; every output is defined from reset onward.

Test Plan:
1. WIDTH=4. Hold reset=0 for 5 clk, then release. parallel_out=0000, busy=0, done=0 throughout. Async check: assert reset between edges with register=1010 → parallel_out=0000 before the next edge.
2. WIDTH=4, mode=11, parallel_in=0010 → next edge parallel_out=0010. mode=00 for 3 edges → stays 0010.
3. WIDTH=4, load 1001. mode=01 with serial_in_left=1 → 1100, then 1110. Then mode=10 with serial_in_right=0 → 1100, then 1000.
4. WIDTH=8, parallel_in=8'hA5, dir=0, start pulse:
   - serial_out_lsb sequence over 8 cycles = 1,0,1,0,0,1,0,1.
   - busy high for 8 cycles; done pulses once after the 8th shift.
   - mode=11 and start=1 applied mid-transfer have no effect.
5. WIDTH=8, dir=1, word 8'h3C:
   - serial_out_msb = 0,0,1,1,1,1,0,0.
   - start=1 with word 8'hFF in the done cycle → second transfer begins with no idle gap; busy re-asserts on the next edge.
6. WIDTH=8, reset asserted on the 3rd SHIFT cycle → busy=0, parallel_out=00 immediately. No done pulse follows. After release, the next start behaves normally.
